// File: rtl/eaglesong_pkg.sv
// Shared sizes, FSM state type and packed-state helpers for the Eaglesong round datapath.
package eaglesong_pkg;

  localparam int NUM_WORDS   = 16;
  localparam int WORD_WIDTH  = 32;
  localparam int STATE_WIDTH = NUM_WORDS * WORD_WIDTH;
  localparam int MATRIX_BITS = 256;
  localparam int INDEX_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } step_state_t;

  function automatic logic [WORD_WIDTH-1:0] word_sel(input logic [STATE_WIDTH-1:0] vec,
                                                     input int unsigned k);
    return vec[k*WORD_WIDTH +: WORD_WIDTH];
  endfunction

endpackage

// File: rtl/eaglesong_bit_matrix_step_if.sv
// Step request/result bundle between a round controller and the bit-matrix step engine.
interface eaglesong_bit_matrix_step_if
  #(parameter int WORD_WIDTH = eaglesong_pkg::WORD_WIDTH);

  logic                                        start;
  logic [eaglesong_pkg::NUM_WORDS*WORD_WIDTH-1:0] state_in;
  logic                                        ready;
  logic                                        busy;
  logic                                        done;
  logic [eaglesong_pkg::NUM_WORDS*WORD_WIDTH-1:0] state_out;

  modport master (output start, output state_in,
                  input ready, input busy, input done, input state_out);

  modport slave  (input start, input state_in,
                  output ready, output busy, output done, output state_out);

endinterface

// File: rtl/eaglesong_bit_matrix_step.sv
// Bit-matrix step: walks all 256 matrix bits, one per cycle, XOR-accumulating
// selected input words into 16 output accumulators.
module eaglesong_bit_matrix_step
  #(parameter int WORD_WIDTH = eaglesong_pkg::WORD_WIDTH)
  (
    input  logic                              clk,
    input  logic                              reset,
    eaglesong_bit_matrix_step_if.slave        step,
    output logic [eaglesong_pkg::INDEX_WIDTH-1:0] bit_index_to_request,
    input  logic                              requested_bit
  );

  import eaglesong_pkg::*;

  if (WORD_WIDTH != 32) begin : g_width_check
    $error("eaglesong_bit_matrix_step supports only WORD_WIDTH = 32");
  end

  step_state_t                  state;
  logic [INDEX_WIDTH-1:0]       idx;
  logic [WORD_WIDTH-1:0]        in_latched [NUM_WORDS];
  logic [WORD_WIDTH-1:0]        acc        [NUM_WORDS];
  logic [WORD_WIDTH-1:0]        acc_next   [NUM_WORDS];
  logic [STATE_WIDTH-1:0]       acc_next_packed;
  logic [STATE_WIDTH-1:0]       out_reg;
  logic                         ready_reg;
  logic                         busy_reg;
  logic                         done_reg;

  // idx[7:4] picks the accumulator row, idx[3:0] the input column.
  always_comb begin
    acc_next = acc;
    if (state == RUN && requested_bit)
      acc_next[idx[7:4]] = acc[idx[7:4]] ^ in_latched[idx[3:0]];
    acc_next_packed = '0;
    for (int j = 0; j < NUM_WORDS; j++)
      acc_next_packed[j*WORD_WIDTH +: WORD_WIDTH] = acc_next[j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      out_reg   <= '0;
      for (int j = 0; j < NUM_WORDS; j++) begin
        in_latched[j] <= '0;
        acc[j]        <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (step.start) begin
            for (int j = 0; j < NUM_WORDS; j++) begin
              in_latched[j] <= word_sel(step.state_in, j);
              acc[j]        <= '0;
            end
            idx       <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          // The final index loads the result directly so done and data align.
          if (idx == INDEX_WIDTH'(MATRIX_BITS - 1)) begin
            idx      <= '0;
            done_reg <= 1'b1;
            out_reg  <= acc_next_packed;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bit_index_to_request = idx;
  assign step.ready           = ready_reg;
  assign step.busy            = busy_reg;
  assign step.done            = done_reg;
  assign step.state_out       = out_reg;

endmodule

// File: tb/tb_eaglesong_bit_matrix_step.sv
// Directed bench for the bit-matrix step; the bench itself answers matrix lookups
// and keeps a queue of expected results computed from its own matrix table.
module tb_eaglesong_bit_matrix_step;
  import eaglesong_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [INDEX_WIDTH-1:0] bit_index_to_request;
  logic requested_bit;

  int vectors = 0;
  int miscompares = 0;
  logic [STATE_WIDTH-1:0] sb [$];

  // Row j, bit k holds M[16j+k]; M[0]=1, M[2]=1, M[253]=0.
  logic [15:0] m_rows [16] = '{
    16'h8F5F, 16'h9F5E, 16'hBEBC, 16'hFD78, 16'h7557, 16'h6491, 16'hC922, 16'h9244,
    16'h2489, 16'h4912, 16'h9225, 16'h244B, 16'h4897, 16'h912F, 16'h225F, 16'hD7B5
  };

  eaglesong_bit_matrix_step_if #(.WORD_WIDTH(32)) step_if ();

  eaglesong_bit_matrix_step #(.WORD_WIDTH(32)) dut (
    .clk                  (clk),
    .reset                (reset),
    .step                 (step_if.slave),
    .bit_index_to_request (bit_index_to_request),
    .requested_bit        (requested_bit)
  );

  assign requested_bit = m_rows[bit_index_to_request[7:4]][bit_index_to_request[3:0]];

  always #5 clk = ~clk;

  function automatic logic [STATE_WIDTH-1:0] model(input logic [STATE_WIDTH-1:0] vec);
    logic [STATE_WIDTH-1:0] res;
    res = '0;
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 16; k++)
        if (m_rows[j][k]) res[j*32 +: 32] = res[j*32 +: 32] ^ vec[k*32 +: 32];
    return res;
  endfunction

  function automatic logic [STATE_WIDTH-1:0] rand_state();
    logic [STATE_WIDTH-1:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [STATE_WIDTH-1:0] obs,
                             input logic [STATE_WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one full step; done must appear right after the 256th edge following the start edge.
  task automatic applyStimulus(input logic [STATE_WIDTH-1:0] vec, input bit extra_starts,
                               input bit scramble, input bit check_sweep);
    logic [STATE_WIDTH-1:0] exp;
    int  edges;
    bit  seen;
    bit  sweep_ok;
    @(negedge clk);
    checkOutput("ready_before_start", step_if.ready, 1);
    step_if.start    = 1'b1;
    step_if.state_in = vec;
    sb.push_back(model(vec));
    @(posedge clk); #1;
    step_if.start = 1'b0;
    edges    = 0;
    seen     = 1'b0;
    sweep_ok = (bit_index_to_request == 8'd0);
    while (!seen && edges < 400) begin
      if (extra_starts) step_if.start = 1'($urandom_range(0, 1));
      if (scramble) step_if.state_in = rand_state();
      @(posedge clk); #1;
      edges++;
      if (step_if.done) seen = 1'b1;
      else if (edges <= 255 && bit_index_to_request !== edges[7:0]) sweep_ok = 1'b0;
    end
    step_if.start = 1'b0;
    checkOutput("done_latency", edges, 256);
    if (check_sweep) checkOutput("index_sweep", sweep_ok, 1);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    checkOutput("state_out", step_if.state_out, exp);
    checkOutput("busy_in_done", step_if.busy, 1);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", step_if.done, 0);
    checkOutput("ready_after_done", step_if.ready, 1);
    checkOutput("state_out_held", step_if.state_out, exp);
  endtask

  initial begin
    logic [STATE_WIDTH-1:0] vec;
    bit no_done;
    step_if.start    = 1'b0;
    step_if.state_in = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_ready", step_if.ready, 1);
    checkOutput("reset_busy", step_if.busy, 0);
    checkOutput("reset_done", step_if.done, 0);
    checkOutput("reset_state_out", step_if.state_out, '0);
    checkOutput("reset_index", bit_index_to_request, '0);

    applyStimulus('0, 1'b0, 1'b0, 1'b1);

    vec = '0; vec[31:0] = 32'hA5A5A5A5;
    applyStimulus(vec, 1'b0, 1'b0, 1'b0);
    checkOutput("word0_a5", step_if.state_out[31:0], 32'hA5A5A5A5);

    vec = '0; vec[2*32 +: 32] = 32'h00000001;
    applyStimulus(vec, 1'b0, 1'b0, 1'b0);
    checkOutput("word0_from_in2", step_if.state_out[31:0], 32'h00000001);

    vec = '0; vec[13*32 +: 32] = 32'hFFFFFFFF;
    applyStimulus(vec, 1'b0, 1'b0, 1'b1);
    checkOutput("word15_no_in13", step_if.state_out[15*32 +: 32], 32'h0);

    for (int r = 0; r < 20; r++)
      applyStimulus(rand_state(), r[0], 1'b0, 1'b0);

    // Abort a step with reset part-way through RUN.
    @(negedge clk);
    vec = rand_state();
    step_if.start    = 1'b1;
    step_if.state_in = vec;
    sb.push_back(model(vec));
    @(posedge clk); #1;
    step_if.start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(sb.pop_front());
    checkOutput("abort_ready", step_if.ready, 1);
    checkOutput("abort_busy", step_if.busy, 0);
    checkOutput("abort_state_out", step_if.state_out, '0);
    no_done = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (step_if.done) no_done = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("abort_no_done", no_done, 1);

    applyStimulus(rand_state(), 1'b0, 1'b0, 1'b0);
    applyStimulus(rand_state(), 1'b1, 1'b1, 1'b1);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
